// File: rtl/mc_fft_sched_if.sv
// Signal bundle between the FFT frame scheduler and its surroundings
// (sample source, shared FFT core, spectrum buffer, delta store, output stage).
interface mc_fft_sched_if #(
  parameter int unsigned N = 256
);
  localparam int unsigned AW = $clog2(N);

  logic          in_valid;
  logic          in_ready;
  logic          fft_in_valid;
  logic          fft_in_sel;
  logic          fft_out_valid;
  logic          buf_wr_en;
  logic [AW-1:0] buf_wr_addr;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          out_en;
  logic [AW-1:0] out_idx;
  logic          frame_done;
  logic          err;
  logic          busy;

  modport master (
    input  in_valid, fft_out_valid,
    output in_ready, fft_in_valid, fft_in_sel, buf_wr_en, buf_wr_addr,
           rd_en, rd_addr, out_en, out_idx, frame_done, err, busy
  );

  modport slave (
    output in_valid, fft_out_valid,
    input  in_ready, fft_in_valid, fft_in_sel, buf_wr_en, buf_wr_addr,
           rd_en, rd_addr, out_en, out_idx, frame_done, err, busy
  );
endinterface

// File: rtl/mc_fft_sched.sv
// Time-shares one FFT core between the forward pass on x and the inverse pass on
// the product spectrum; phases advance on the core's out_valid, not on cycle counts.
module mc_fft_sched #(
  parameter int unsigned N        = 256,
  parameter int unsigned MULT_LAT = 2
) (
  input logic             clk,
  input logic             rst_n,
  mc_fft_sched_if.master  bus
);
  localparam int unsigned AW = $clog2(N);
  localparam int unsigned CW = AW + 1;

  localparam logic [CW-1:0] LastIdx = CW'(N - 1);
  localparam logic [CW-1:0] NCnt    = CW'(N);
  localparam logic [CW-1:0] IssLat  = CW'(MULT_LAT);
  localparam logic [CW-1:0] IssEnd  = CW'(N + MULT_LAT);
  localparam logic [CW-1:0] IssLast = CW'(N - 1 + MULT_LAT);

  typedef enum logic [2:0] {StIdle, StLoad, StFwd, StMult, StInv, StDone} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] in_cnt_q, in_cnt_d;
  logic [CW-1:0] cap_cnt_q, cap_cnt_d;
  logic [CW-1:0] iss_cnt_q, iss_cnt_d;
  logic          err_q, err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      in_cnt_q  <= '0;
      cap_cnt_q <= '0;
      iss_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_cnt_q  <= in_cnt_d;
      cap_cnt_q <= cap_cnt_d;
      iss_cnt_q <= iss_cnt_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    in_cnt_d         = in_cnt_q;
    cap_cnt_d        = cap_cnt_q;
    iss_cnt_d        = iss_cnt_q;
    err_d            = 1'b0;
    bus.in_ready     = 1'b0;
    bus.fft_in_valid = 1'b0;
    bus.fft_in_sel   = 1'b0;
    bus.buf_wr_en    = 1'b0;
    bus.rd_en        = 1'b0;
    bus.out_en       = 1'b0;
    bus.frame_done   = 1'b0;

    unique case (state_q)
      StIdle: begin
        bus.in_ready     = 1'b1;
        bus.fft_in_valid = bus.in_valid;
        if (bus.in_valid) begin
          in_cnt_d = CW'(1);
          state_d  = StLoad;
        end
      end
      StLoad: begin
        bus.in_ready     = 1'b1;
        bus.fft_in_valid = bus.in_valid;
        if (bus.in_valid) begin
          if (in_cnt_q == LastIdx) begin
            in_cnt_d = '0;
            state_d  = StFwd;
          end else begin
            in_cnt_d = in_cnt_q + CW'(1);
          end
        end else begin
          // Short frame: abandon it; the partial data is flushed by the next frame.
          err_d     = 1'b1;
          in_cnt_d  = '0;
          cap_cnt_d = '0;
          iss_cnt_d = '0;
          state_d   = StIdle;
        end
      end
      StFwd: begin
        bus.buf_wr_en = bus.fft_out_valid;
        if (bus.fft_out_valid) begin
          if (cap_cnt_q == LastIdx) begin
            cap_cnt_d = '0;
            state_d   = StMult;
          end else begin
            cap_cnt_d = cap_cnt_q + CW'(1);
          end
        end
      end
      StMult: begin
        // Reads lead the core input by the multiplier pipeline depth.
        bus.rd_en        = (iss_cnt_q < NCnt);
        bus.fft_in_valid = (iss_cnt_q >= IssLat) && (iss_cnt_q < IssEnd);
        bus.fft_in_sel   = 1'b1;
        if (iss_cnt_q == IssLast) begin
          iss_cnt_d = '0;
          state_d   = StInv;
        end else begin
          iss_cnt_d = iss_cnt_q + CW'(1);
        end
      end
      StInv: begin
        bus.out_en     = bus.fft_out_valid;
        bus.fft_in_sel = 1'b1;
        if (bus.fft_out_valid) begin
          if (cap_cnt_q == LastIdx) begin
            cap_cnt_d = '0;
            state_d   = StDone;
          end else begin
            cap_cnt_d = cap_cnt_q + CW'(1);
          end
        end
      end
      StDone: begin
        bus.frame_done = 1'b1;
        bus.fft_in_sel = 1'b1;
        state_d        = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.buf_wr_addr = cap_cnt_q[AW-1:0];
  assign bus.out_idx     = cap_cnt_q[AW-1:0];
  assign bus.rd_addr     = iss_cnt_q[AW-1:0];
  assign bus.err         = err_q;
  assign bus.busy        = (state_q != StIdle);

endmodule

// File: doc/mc_fft_sched.md
# mc_fft_sched

Frame scheduler for the Monte-Carlo convolution pipeline. It time-shares one 256-point FFT core between the forward pass on x and the inverse pass on the product spectrum. It sequences four phases, in order: input load, forward-spectrum capture, multiply/re-inject, and inverse-output capture. It drives the core's input mux, the spectrum buffer write port, the shared buffer/delta read address, and the output strobe. It replaces ad-hoc absolute-cycle compares with a state machine that tracks the core's `out_valid`, so it is independent of core latency.

## Interface
- `N`, 256: points per frame; power of two; counters are log2(N) bits plus one guard bit.
- `MULT_LAT`, 2: cycles from `rd_addr` issue to the product appearing at the core input (operand register plus product register); range 1..7.
- `clk` input 1: single clock; all state updates on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: external sample strobe; a frame is exactly N consecutive high cycles.
- `fft_out_valid` input 1: `out_valid` from the shared FFT core.
- `in_ready` output 1: high in IDLE and LOAD.
- `fft_in_valid` output 1: `in_valid` to the FFT core.
- `fft_in_sel` output 1: 0 selects external x (imaginary part forced to 0); 1 selects the product with imaginary part negated (conjugate trick for IFFT).
- `buf_wr_en` output 1: spectrum buffer write strobe.
- `buf_wr_addr` output log2(N): spectrum buffer write index.
- `rd_en` output 1: read strobe for spectrum buffer and delta store.
- `rd_addr` output log2(N): shared read index.
- `out_en` output 1: final-output strobe (downstream conjugates and applies `>>>8`).
- `out_idx` output log2(N): index of the current output sample.
- `frame_done` output 1: one-cycle pulse after the last output.
- `err` output 1: one-cycle pulse when a short frame is detected.
- `busy` output 1: state != IDLE.

## Operation
- States: IDLE, LOAD, FWD, MULT, INV, DONE. Counters: `in_cnt`, `cap_cnt`, `iss_cnt` (each log2(N)+1 bits).
- IDLE:
  - `in_valid`=1 sets `fft_in_valid`=1 combinationally and `fft_in_sel`=0.
  - `in_cnt`←1; next state LOAD.
- LOAD:
  - `fft_in_valid` = `in_valid`; each high cycle increments `in_cnt`.
  - The cycle that accepts sample N-1 moves to FWD with `in_cnt` cleared.
  - `in_valid`=0 before N samples: `err` pulses, counters clear, next state IDLE. The core is flushed by the next full frame.
- FWD:
  - `buf_wr_en` = `fft_out_valid`; `buf_wr_addr` = `cap_cnt`; `cap_cnt` increments per write.
  - After write N-1: `cap_cnt`←0, next state MULT.
- MULT: `iss_cnt` counts 0 .. N-1+MULT_LAT, one step per cycle.
  - `rd_en` = (`iss_cnt` < N); `rd_addr` = `iss_cnt`[log2(N)-1:0].
  - `fft_in_valid` = (`iss_cnt` >= MULT_LAT) && (`iss_cnt` < N+MULT_LAT); `fft_in_sel`=1.
  - At `iss_cnt` = N-1+MULT_LAT: `iss_cnt`←0, next state INV.
- INV:
  - `out_en` = `fft_out_valid`; `out_idx` = `cap_cnt`; `cap_cnt` increments per output.
  - After output N-1: next state DONE.
- DONE: `frame_done`=1 for this cycle; next state IDLE.
- `in_valid` outside IDLE/LOAD is ignored: never forwarded to the core, no `err`.
- `fft_out_valid` in IDLE, LOAD, MULT or DONE is ignored: no buffer write, no `out_en`.
- `fft_in_sel` holds 1 from MULT entry until DONE exit, so the mux is stable while the core drains. It is 0 in all other states.

## Timing
- Reset value of every output is 0, except `in_ready`=1. State resets to IDLE and all counters to 0. Reset is effective immediately (asynchronous) and releases on a clock edge.
- Reset asserted mid-frame aborts the frame. No `frame_done` or `err` is issued.
- LOAD: zero latency from `in_valid` to `fft_in_valid`.
- All other strobes are decoded from registered state/counters, so they are glitch-free.
- First `fft_in_valid` in MULT occurs exactly MULT_LAT cycles after the first `rd_en`. The product sequence is gapless (N cycles).
- FWD→MULT: the first `rd_en` is in the cycle after the write of index N-1, so the read-after-write hazard is avoided.
- Frame period = N + T_fwd + N + MULT_LAT + T_inv + 1 cycles, where T_fwd and T_inv are the core's latencies as observed on `fft_out_valid`. The next frame is accepted in the cycle after `frame_done`.
- Counter wrap: indices are the low log2(N) bits. The guard bit exists only for the `iss_cnt` < N+MULT_LAT compare.

## Test plan
- Nominal frame: 256 `in_valid` cycles; model the core with a fixed 270-cycle latency.
  - 256 `buf_wr_en` on addresses 0..255.
  - `rd_addr` 0..255 contiguous; `fft_in_valid` with sel=1 starting exactly 2 cycles after the first `rd_en`.
  - 256 `out_en` on `out_idx` 0..255; `frame_done` one cycle after the last `out_en`.
- Short frame: `in_valid` drops after 100 samples.
  - `err` pulses once; `busy`→0; no `buf_wr_en` occurs; the next full frame completes normally.
- Gapped core output: `fft_out_valid` toggles 1/0 in FWD.
  - Writes occur only on high cycles; addresses stay contiguous 0..255; MULT entered after write 255 only.
- Stray inputs: `in_valid` pulsed during MULT, and `fft_out_valid` pulsed in LOAD.
  - No extra `fft_in_valid`, `buf_wr_en` or `out_en`; `iss_cnt` sequence unchanged.
- Reset mid-MULT (`iss_cnt`=120): all outputs drop to reset values asynchronously, `in_ready`=1, and a fresh frame after release runs to `frame_done`.
- MULT_LAT=5 build: the first product `fft_in_valid` is 5 cycles after `rd_en`, and the MULT state spans 261 cycles.
